// File: rtl/pe_fu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_fu_pkg
// Purpose  : Shared opcode map, FSM state type and opcode helpers for the
//            registered PE functional unit.
// Revision : 1.0  initial release
// ============================================================================
package pe_fu_pkg;

  // Opcode encodings; they are compared against a zero-extended OP_W field,
  // so these values hold for any opcode width of four bits or more.
  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_MULT = 2;
  localparam int unsigned OP_SLL  = 3;
  localparam int unsigned OP_SRL  = 4;
  localparam int unsigned OP_AND  = 5;
  localparam int unsigned OP_OR   = 6;
  localparam int unsigned OP_NOT  = 7;
  localparam int unsigned OP_XOR  = 8;
  localparam int unsigned OP_SRA  = 9;
  localparam int unsigned OP_SLT  = 10;
  localparam int unsigned OP_SLTU = 11;
  localparam int unsigned OP_PASS = 12;

  // Multiply countdown width; MUL_STAGES is limited to 1..4.
  localparam int unsigned CNT_W = 3;

  // IDLE: nothing held. MUL: multiply in flight. HOLD: result waiting.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } fu_state_e;

  // Everything above the last defined opcode returns zero with op_err set.
  function automatic logic is_undef_op(input int unsigned op);
    return (op > OP_PASS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fu_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fu_mul_pipe
// Purpose  : DATA_W x DATA_W -> DATA_W (low half) multiplier with STAGES
//            enabled register stages. Data registers carry no reset; the
//            owning control logic decides when the output is meaningful.
// Revision : 1.0  initial release
// ============================================================================
module fu_mul_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] p
);

  logic [DATA_W-1:0] prod_d;
  logic [DATA_W-1:0] stage_q [STAGES];

  // Low half of the unsigned product feeds the first stage.
  always_comb begin
    prod_d = a * b;
  end

  // Advance the whole pipe only when the controller enables it, so a
  // finished product stays put while the result is being held.
  always_ff @(posedge clk) begin
    if (en) begin
      stage_q[0] <= prod_d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign p = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pe_fu_seq.sv
`default_nettype none
// ============================================================================
// Module   : pe_fu_seq
// Purpose  : Registered PE functional unit with valid/ready handshake.
//            Single-cycle ALU ops, pipelined multiply, one op in flight,
//            back-pressure holds the result instead of dropping it.
// Revision : 1.0  initial release
// ============================================================================
module pe_fu_seq #(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 4,
  parameter int MUL_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   fu_opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] fu_result,
  output logic              op_err
);

  import pe_fu_pkg::*;

  localparam int SH_W = $clog2(DATA_W);

  fu_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              err_q, err_d;
  logic              sel_mul_q, sel_mul_d;

  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] mul_out;
  logic [SH_W-1:0]   sh_amt;
  logic              sh_big;
  logic              op_undef;
  logic              op_is_mul;
  logic              accept;
  logic              mul_en;

  // Combinational ALU for all single-cycle opcodes.
  always_comb begin
    sh_amt    = b[SH_W-1:0];
    sh_big    = (b >= DATA_W'(DATA_W));
    op_undef  = is_undef_op(32'(fu_opcode));
    op_is_mul = (32'(fu_opcode) == OP_MULT);
    alu_res   = '0;
    case (32'(fu_opcode))
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLL:  alu_res = sh_big ? '0 : (a << sh_amt);
      OP_SRL:  alu_res = sh_big ? '0 : (a >> sh_amt);
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOT:  alu_res = ~a;
      OP_XOR:  alu_res = a ^ b;
      OP_SRA:  alu_res = sh_big ? {DATA_W{a[DATA_W-1]}}
                                : DATA_W'($unsigned($signed(a) >>> sh_amt));
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_PASS: alu_res = a;
      default: alu_res = '0;
    endcase
  end

  // Multiplier pipe; it only advances on a multiply accept or while in MUL.
  fu_mul_pipe #(
    .DATA_W (DATA_W),
    .STAGES (MUL_STAGES)
  ) u_mul (
    .clk (clk),
    .en  (mul_en),
    .a   (a),
    .b   (b),
    .p   (mul_out)
  );

  // Handshake outputs: in_ready is the only combinational path (from out_ready).
  always_comb begin
    in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    out_valid = (state_q == ST_HOLD);
    fu_result = sel_mul_q ? mul_out : res_q;
    op_err    = err_q;
  end

  // Next-state and result-capture logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    err_d     = err_q;
    sel_mul_d = sel_mul_q;
    mul_en    = 1'b0;
    accept    = in_valid && in_ready;
    if (accept) begin
      if (op_is_mul) begin
        // Clear the ALU result so fu_result reads zero while the multiply runs.
        mul_en = 1'b1;
        res_d  = '0;
        err_d  = 1'b0;
        if (MUL_STAGES == 1) begin
          state_d   = ST_HOLD;
          cnt_d     = '0;
          sel_mul_d = 1'b1;
        end else begin
          state_d   = ST_MUL;
          cnt_d     = CNT_W'(MUL_STAGES - 1);
          sel_mul_d = 1'b0;
        end
      end else begin
        state_d   = ST_HOLD;
        res_d     = alu_res;
        err_d     = op_undef;
        sel_mul_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_MUL: begin
          // The edge that takes the count to zero lands the product.
          mul_en = 1'b1;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d   = ST_HOLD;
            sel_mul_d = 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State and result registers; reset discards any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      sel_mul_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      err_q     <= err_d;
      sel_mul_q <= sel_mul_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_fu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_fu_seq
// Purpose  : Directed bench for pe_fu_seq (DATA_W=32, OP_W=4, MUL_STAGES=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_pe_fu_seq;

  localparam int DW = 32;
  localparam int OW = 4;
  localparam int MS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic [OW-1:0] fu_opcode = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] fu_result;
  logic          op_err;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
    logic          err;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  pe_fu_seq #(
    .DATA_W     (DW),
    .OP_W       (OW),
    .MUL_STAGES (MS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .fu_opcode (fu_opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fu_result (fu_result),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [OW-1:0] op, input logic [DW-1:0] va, input logic [DW-1:0] vb);
    fu_opcode = op;
    a         = va;
    b         = vb;
    in_valid  = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0}; // ADD wrap
    vecs[1]  = '{4'd1,  32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0}; // SUB
    vecs[2]  = '{4'd10, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0}; // SLT -1<1
    vecs[3]  = '{4'd11, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0}; // SLTU
    vecs[4]  = '{4'd9,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0}; // SRA 31
    vecs[5]  = '{4'd9,  32'h8000_0000, 32'd40,        32'hFFFF_FFFF, 1'b0}; // SRA big
    vecs[6]  = '{4'd3,  32'd1,         32'd32,        32'h0000_0000, 1'b0}; // SLL 32
    vecs[7]  = '{4'd15, 32'h1234_5678, 32'd9,         32'h0000_0000, 1'b1}; // undef 15
    vecs[8]  = '{4'd3,  32'd1,         32'd4,         32'h0000_0010, 1'b0}; // SLL 4
    vecs[9]  = '{4'd4,  32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0}; // SRL 31
    vecs[10] = '{4'd4,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0}; // SRL huge b
    vecs[11] = '{4'd5,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0}; // AND
    vecs[12] = '{4'd6,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0}; // OR
    vecs[13] = '{4'd7,  32'h0000_FFFF, 32'd0,         32'hFFFF_0000, 1'b0}; // NOT
    vecs[14] = '{4'd8,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0}; // XOR
    vecs[15] = '{4'd12, 32'h1234_5678, 32'd0,         32'h1234_5678, 1'b0}; // PASS
    vecs[16] = '{4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1}; // undef 13
    vecs[17] = '{4'd9,  32'h4000_0000, 32'd4,         32'h0400_0000, 1'b0}; // SRA pos
    vecs[18] = '{4'd10, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0}; // SLT 1<-1

    // Reset state, during and after release.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_out_valid_rel", 32'(out_valid), 32'd0);
    chk("rst_fu_result", fu_result, 32'd0);
    chk("rst_op_err", 32'(op_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back single-cycle ops with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      step();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_result", i), fu_result, vecs[i].exp);
      chk($sformatf("v%0d_op_err", i), 32'(op_err), 32'(vecs[i].err));
    end
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Two multiplies: first wraps to zero, second 3*4.
    drive(4'd2, 32'h0001_0000, 32'h0001_0000);
    step();                                // accept edge
    chk("m1_in_ready_busy", 32'(in_ready), 32'd0);
    chk("m1_out_valid_busy", 32'(out_valid), 32'd0);
    drive(4'd2, 32'd3, 32'd4);             // held while unit is busy
    step();
    chk("m1_out_valid", 32'(out_valid), 32'd1);
    chk("m1_result", fu_result, 32'd0);
    chk("m1_op_err", 32'(op_err), 32'd0);
    chk("m2_in_ready_hold", 32'(in_ready), 32'd1);
    step();                                // second multiply accepted
    in_valid = 1'b0;
    chk("m2_in_ready_busy", 32'(in_ready), 32'd0);
    chk("m2_out_valid_busy", 32'(out_valid), 32'd0);
    step();
    chk("m2_out_valid", 32'(out_valid), 32'd1);
    chk("m2_result", fu_result, 32'd12);
    step();
    chk("m2_drain", 32'(out_valid), 32'd0);

    // Back-pressure: XOR result held for 5 cycles, new request ignored.
    drive(4'd8, 32'h0000_F0F0, 32'h0000_FF00);
    step();
    out_ready = 1'b0;
    drive(4'd0, 32'd1, 32'd1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_result", k), fu_result, 32'h0000_0FF0);
      chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", 32'(in_ready), 32'd1);
    chk("stall_release_result", fu_result, 32'h0000_0FF0);
    step();
    in_valid = 1'b0;
    chk("stall_next_valid", 32'(out_valid), 32'd1);
    chk("stall_next_result", fu_result, 32'd2);
    step();
    chk("stall_drain", 32'(out_valid), 32'd0);

    // Reset one cycle after a multiply accept: the product never appears.
    drive(4'd2, 32'd3, 32'd4);
    step();
    in_valid = 1'b0;
    chk("rm_busy", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rm_in_reset_valid", 32'(out_valid), 32'd0);
    chk("rm_in_reset_result", fu_result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rm%0d_out_valid", k), 32'(out_valid), 32'd0);
      chk($sformatf("rm%0d_result", k), fu_result, 32'd0);
      chk($sformatf("rm%0d_in_ready", k), 32'(in_ready), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
